// File: rtl/char_buf_pkg.sv
// Shared constants and command encoding for the character buffer controller.
package char_buf_pkg;

  localparam int unsigned COLS      = 80;
  localparam int unsigned ROWS      = 24;
  localparam int unsigned BUF_SIZE  = COLS * ROWS;
  localparam int unsigned ADDR_BITS = 11;
  localparam int unsigned ROW_BITS  = 5;
  localparam int unsigned COL_BITS  = 7;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    OP_CLEAR     = 2'd0,
    OP_ERASE_EOL = 2'd1,
    OP_ERASE_EOS = 2'd2,
    OP_SCROLL_UP = 2'd3
  } cmd_op_e;

endpackage

// File: rtl/char_addr_map.sv
// Maps a logical (row, col) on a scrolled screen to a physical buffer address.
module char_addr_map #(
  parameter int unsigned COLS      = char_buf_pkg::COLS,
  parameter int unsigned ROWS      = char_buf_pkg::ROWS,
  parameter int unsigned ADDR_BITS = char_buf_pkg::ADDR_BITS
) (
  input  logic [4:0]           first_row,
  input  logic [4:0]           row,
  input  logic [6:0]           col,
  output logic [ADDR_BITS-1:0] addr_c
);

  logic [5:0]           row_sum_c;
  logic [4:0]           row_phys_c;
  logic [ADDR_BITS-1:0] row_base_c;

  // Screen row to physical row; both operands are below ROWS so one subtract wraps
  always_comb begin
    row_sum_c  = {1'b0, first_row} + {1'b0, row};
    row_phys_c = row_sum_c[4:0];
    if (row_sum_c >= 6'(ROWS)) begin
      row_phys_c = 5'(row_sum_c - 6'(ROWS));
    end
  end

  // Row times line length; the 80-column case is r*64 + r*16
  if (COLS == 32'd80) begin : g_shift_add
    assign row_base_c = (ADDR_BITS'(row_phys_c) << 6) + (ADDR_BITS'(row_phys_c) << 4);
  end else begin : g_generic
    assign row_base_c = ADDR_BITS'(32'(row_phys_c) * COLS);
  end

  assign addr_c = row_base_c + ADDR_BITS'(col);

endmodule

// File: rtl/char_buffer_ctrl.sv
// Character buffer write controller: direct character writes plus blank fills
// for clear / erase / scroll commands on a circular row buffer.
// Optional build macro CHAR_BUF_CTRL_CLEAR_ON_RESET_EN: blank the whole screen
// after reset release before accepting any traffic.
module char_buffer_ctrl #(
  parameter int unsigned COLS      = char_buf_pkg::COLS,
  parameter int unsigned ROWS      = char_buf_pkg::ROWS,
  parameter int unsigned ADDR_BITS = char_buf_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [4:0]           wr_row,
  input  logic [6:0]           wr_col,
  input  logic [7:0]           wr_char,
  input  logic                 wr_graphic,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [4:0]           cmd_row,
  input  logic [6:0]           cmd_col,
  output logic [ADDR_BITS-1:0] buf_waddr,
  output logic [7:0]           buf_din,
  output logic                 buf_wen,
  output logic                 buf_graphic,
  output logic [4:0]           first_row,
  output logic                 busy
);

  import char_buf_pkg::*;

  localparam int unsigned FILL_SIZE      = ROWS * COLS;
  localparam int unsigned LAST_ROW_START = (ROWS - 1) * COLS;
  localparam int unsigned PW             = ADDR_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef CHAR_BUF_CTRL_CLEAR_ON_RESET_EN
    ST_FILL = 2'd1,
    ST_INIT = 2'd2
`else
    ST_FILL = 2'd1
`endif
  } state_e;

  state_e               state_q;
  logic [4:0]           first_row_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [ADDR_BITS-1:0] end_q;

  logic [ADDR_BITS-1:0] wr_addr_c;
  logic [ADDR_BITS-1:0] cmd_lin_c;
  logic [ADDR_BITS-1:0] fill_base_c;
  logic [PW-1:0]        fill_sum_c;
  logic [ADDR_BITS-1:0] fill_phys_c;
  logic [ADDR_BITS-1:0] cmd_eol_end_c;
  logic [ADDR_BITS-1:0] idx_next_c;
  logic [4:0]           scroll_next_c;
  logic                 wr_in_range_c;
  logic                 cmd_pos_ok_c;

  // Physical address of a character write on the current screen
  char_addr_map #(.COLS(COLS), .ROWS(ROWS), .ADDR_BITS(ADDR_BITS)) u_wr_map (
    .first_row (first_row_q),
    .row       (wr_row),
    .col       (wr_col),
    .addr_c    (wr_addr_c)
  );

  // Unscrolled linear index of the command cursor (fill range start)
  char_addr_map #(.COLS(COLS), .ROWS(ROWS), .ADDR_BITS(ADDR_BITS)) u_cmd_map (
    .first_row (5'd0),
    .row       (cmd_row),
    .col       (cmd_col),
    .addr_c    (cmd_lin_c)
  );

  // first_row * COLS, the offset that rotates logical fill indices
  char_addr_map #(.COLS(COLS), .ROWS(ROWS), .ADDR_BITS(ADDR_BITS)) u_base_map (
    .first_row (first_row_q),
    .row       (5'd0),
    .col       (7'd0),
    .addr_c    (fill_base_c)
  );

  // Fill address rotation, range bounds and position checks
  always_comb begin
    fill_sum_c    = PW'(idx_q) + PW'(fill_base_c);
    fill_phys_c   = ADDR_BITS'(fill_sum_c);
    if (fill_sum_c >= PW'(FILL_SIZE)) begin
      fill_phys_c = ADDR_BITS'(fill_sum_c - PW'(FILL_SIZE));
    end
    cmd_eol_end_c = cmd_lin_c - ADDR_BITS'(cmd_col) + ADDR_BITS'(COLS);
    idx_next_c    = idx_q + ADDR_BITS'(1);
    scroll_next_c = (first_row_q == 5'(ROWS - 1)) ? 5'd0 : first_row_q + 5'd1;
    wr_in_range_c = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    cmd_pos_ok_c  = (32'(cmd_row) < ROWS) && (32'(cmd_col) < COLS);
  end

  assign wr_ready  = (state_q == ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE) && !wr_valid;
  assign busy      = (state_q != ST_IDLE);
  assign first_row = first_row_q;

  // Controller FSM with registered buffer write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef CHAR_BUF_CTRL_CLEAR_ON_RESET_EN
      state_q <= ST_INIT;
      end_q   <= ADDR_BITS'(FILL_SIZE);
`else
      state_q <= ST_IDLE;
      end_q   <= '0;
`endif
      first_row_q <= '0;
      idx_q       <= '0;
      buf_wen     <= 1'b0;
      buf_waddr   <= '0;
      buf_din     <= '0;
      buf_graphic <= 1'b0;
    end else begin
      buf_wen <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_valid) begin
            if (wr_in_range_c) begin
              buf_wen     <= 1'b1;
              buf_waddr   <= wr_addr_c;
              buf_din     <= wr_char;
              buf_graphic <= wr_graphic;
            end
          end else if (cmd_valid) begin
            case (cmd_op_e'(cmd_op))
              OP_CLEAR: begin
                idx_q   <= '0;
                end_q   <= ADDR_BITS'(FILL_SIZE);
                state_q <= ST_FILL;
              end
              OP_ERASE_EOL: begin
                if (cmd_pos_ok_c) begin
                  idx_q   <= cmd_lin_c;
                  end_q   <= cmd_eol_end_c;
                  state_q <= ST_FILL;
                end
              end
              OP_ERASE_EOS: begin
                if (cmd_pos_ok_c) begin
                  idx_q   <= cmd_lin_c;
                  end_q   <= ADDR_BITS'(FILL_SIZE);
                  state_q <= ST_FILL;
                end
              end
              default: begin
                first_row_q <= scroll_next_c;
                idx_q       <= ADDR_BITS'(LAST_ROW_START);
                end_q       <= ADDR_BITS'(FILL_SIZE);
                state_q     <= ST_FILL;
              end
            endcase
          end
        end
        default: begin
          buf_wen     <= 1'b1;
          buf_waddr   <= fill_phys_c;
          buf_din     <= BLANK_CHAR;
          buf_graphic <= 1'b0;
          idx_q       <= idx_next_c;
          if (idx_next_c == end_q) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Randomized scoreboard bench for char_buffer_ctrl.
module tb_char_buffer_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 24;
  localparam int SIZE = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, wr_graphic;
  logic [4:0]  wr_row;
  logic [6:0]  wr_col;
  logic [7:0]  wr_char;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_row;
  logic [6:0]  cmd_col;
  logic [10:0] buf_waddr;
  logic [7:0]  buf_din;
  logic        buf_wen, buf_graphic;
  logic [4:0]  first_row;
  logic        busy;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  din;
    logic        g;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   fr_m     = 0;
`ifdef CHAR_BUF_CTRL_CLEAR_ON_RESET_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  char_buffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char), .wr_graphic(wr_graphic),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .buf_waddr(buf_waddr), .buf_din(buf_din), .buf_wen(buf_wen),
    .buf_graphic(buf_graphic), .first_row(first_row), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // Screen position on a scrolled display, straight from the row/col rule
  function automatic int phys(input int fr, input int row, input int col);
    return ((fr + row) % ROWS) * COLS + col;
  endfunction

  // Expected blank writes for logical index range [s, e)
  task automatic push_fill(input int s, input int e);
    exp_t x;
    for (int i = s; i < e; i++) begin
      x.addr = 11'(phys(fr_m, i / COLS, i % COLS));
      x.din  = 8'h20;
      x.g    = 1'b0;
      sb.push_back(x);
    end
  endtask

  // Monitor: every buffer write must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && buf_wen) begin
        if (sb.size() == 0) begin
          timeout("unexpected_write");
        end else begin
          e = sb.pop_front();
          check("waddr", 32'(buf_waddr), 32'(e.addr));
          check("din", 32'(buf_din), 32'(e.din));
          check("graphic", 32'(buf_graphic), 32'(e.g));
          n_writes++;
        end
      end
    end
  end

  task automatic wait_idle(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc > 4000) begin
        timeout("busy");
        break;
      end
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
    check("first_row", 32'(first_row), 32'(fr_m));
    check("wr_ready_idle", 32'(wr_ready), 32'd1);
  endtask

  task automatic do_write(input int row, input int col, input int ch, input bit g);
    int   t;
    exp_t x;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_row = 5'(row); wr_col = 7'(col);
    wr_char = 8'(ch); wr_graphic = g;
    t = 0;
    do begin @(negedge clk); t++; end while (!wr_ready && t < 5000);
    if (!wr_ready) begin
      timeout("wr_ready");
      wr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (row < ROWS && col < COLS) begin
      x.addr = 11'(phys(fr_m, row, col)); x.din = 8'(ch); x.g = g;
      sb.push_back(x);
    end
    #1 wr_valid = 1'b0;
  endtask

  task automatic model_cmd(input int op, input int row, input int col);
    bool_ok: begin end
    case (op)
      0: push_fill(0, SIZE);
      1: if (row < ROWS && col < COLS) push_fill(row * COLS + col, row * COLS + COLS);
      2: if (row < ROWS && col < COLS) push_fill(row * COLS + col, SIZE);
      default: begin
        fr_m = (fr_m + 1) % ROWS;
        push_fill((ROWS - 1) * COLS, SIZE);
      end
    endcase
  endtask

  task automatic do_cmd(input int op, input int row, input int col, input bit wait_done,
                        output int cyc);
    int t;
    cyc = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_row = 5'(row); cmd_col = 7'(col);
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 5000);
    if (!cmd_ready) begin
      timeout("cmd_ready");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_cmd(op, row, col);
    #1 cmd_valid = 1'b0;
    if (wait_done) wait_idle(cyc);
  endtask

  initial begin
    int cyc;
    int target;
    int t;
    exp_t x;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_char = '0; wr_graphic = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0;
    #1;
    check("rst_wen", 32'(buf_wen), 32'd0);
    check("rst_waddr", 32'(buf_waddr), 32'd0);
    check("rst_din", 32'(buf_din), 32'd0);
    check("rst_graphic", 32'(buf_graphic), 32'd0);
    check("rst_first_row", 32'(first_row), 32'd0);
    check("rst_busy", 32'(busy), 32'(INIT_EN));
    #21 rst_n = 1'b1;
    if (INIT_EN) begin
      push_fill(0, SIZE);
      wait_idle(cyc);
      check("init_cycles", 32'(cyc), 32'(SIZE));
    end else begin
      wait_idle(cyc);
    end

    // Single write, one cycle latency
    do_write(0, 0, 8'h41, 1'b0);
    check("a_wen", 32'(buf_wen), 32'd1);
    check("a_waddr", 32'(buf_waddr), 32'd0);
    check("a_din", 32'(buf_din), 32'h41);
    @(negedge clk);

    // Erase to end of line
    do_cmd(1, 2, 70, 1'b1, cyc);
    check("eol_cycles", 32'(cyc), 32'd10);

    // Scroll up to first_row 23, then wrap to 0
    for (int i = 0; i < 23; i++) do_cmd(3, 0, 0, 1'b1, cyc);
    check("fr_23", 32'(first_row), 32'd23);
    do_cmd(3, 0, 0, 1'b1, cyc);
    check("scroll_wrap_fr", 32'(first_row), 32'd0);
    check("scroll_cycles", 32'(cyc), 32'd80);

    // Erase to end of screen with first_row 5
    for (int i = 0; i < 5; i++) do_cmd(3, 0, 0, 1'b1, cyc);
    do_cmd(2, 23, 0, 1'b1, cyc);
    check("eos_cycles", 32'(cyc), 32'd80);

    // Write and command together: write first, command next cycle
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_row = 5'd0; wr_col = 7'd5; wr_char = 8'h5a; wr_graphic = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_row = 5'd1; cmd_col = 7'd75;
    @(negedge clk);
    check("both_wr_ready", 32'(wr_ready), 32'd1);
    check("both_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    x.addr = 11'(phys(fr_m, 0, 5)); x.din = 8'h5a; x.g = 1'b1;
    sb.push_back(x);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    check("both_cmd_next", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    model_cmd(1, 1, 75);
    #1 cmd_valid = 1'b0;
    wait_idle(cyc);
    check("both_cmd_cycles", 32'(cyc), 32'd5);

    // Random traffic, including out-of-range positions
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        do_write(int'($urandom_range(0, 25)), int'($urandom_range(0, 84)),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end else begin
        do_cmd(int'($urandom_range(1, 3)), int'($urandom_range(0, 25)),
               int'($urandom_range(0, 84)), 1'b1, cyc);
      end
    end
    @(negedge clk); #1;
    check("rand_drain", 32'(sb.size()), 32'd0);

    // Reset in the middle of a clear screen
    if (fr_m == 0) do_cmd(3, 0, 0, 1'b1, cyc);
    target = n_writes + 100;
    do_cmd(0, 0, 0, 1'b0, cyc);
    t = 0;
    while (n_writes < target && t < 1000) begin @(posedge clk); t++; end
    if (n_writes < target) timeout("clear_progress");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wen", 32'(buf_wen), 32'd0);
    check("mid_rst_fr", 32'(first_row), 32'd0);
    check("mid_rst_waddr", 32'(buf_waddr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'(INIT_EN));
    sb.delete();
    fr_m = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    if (INIT_EN) push_fill(0, SIZE);
    wait_idle(cyc);
    check("post_rst_cycles", 32'(cyc), INIT_EN ? 32'(SIZE) : 32'd0);

    do_write(3, 79, 8'h7e, 1'b0);
    @(negedge clk); #1;
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/char_buffer_ctrl.md
CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

Interface
REQ-001 Parameter COLS, default 80, characters per line.
REQ-002 Parameter ROWS, default 24, lines per screen.
REQ-003 Parameter ADDR_BITS, default 11, width of the buffer address.
REQ-004 Port clk  input  1  single clock, all logic rising-edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port wr_valid / wr_ready  input / output  1 / 1  character-write handshake.
REQ-007 Port wr_row, wr_col, wr_char, wr_graphic  input  5, 7, 8, 1  logical row, column, code and graphic attribute.
REQ-008 Port cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-009 Port cmd_op  input  2  command: 0 clear screen, 1 erase to end of line, 2 erase to end of screen, 3 scroll up.
REQ-010 Port cmd_row, cmd_col  input  5, 7  cursor position for ops 1 and 2.
REQ-011 Port buf_waddr, buf_din, buf_wen, buf_graphic  output  ADDR_BITS, 8, 1, 1  char buffer write port.
REQ-012 Port first_row  output  5  physical row shown as screen line 0, used by the video read side.
REQ-013 Port busy  output  1  high while a fill is in progress.

Function
REQ-014 Physical address SHALL be ((first_row + row) mod ROWS) * COLS + col; the modulo SHALL be a single conditional subtract of ROWS.
REQ-015 All buf_* outputs SHALL be registered; a transfer accepted in cycle N SHALL produce its buffer write in cycle N+1.
REQ-016 FSM states SHALL be IDLE and FILL, plus INIT when CHAR_BUF_CTRL_CLEAR_ON_RESET_EN is defined.
REQ-017 wr_ready SHALL be high only in IDLE; cmd_ready SHALL be high only in IDLE with wr_valid low, so a write wins over a simultaneous command.
REQ-018 An accepted write with wr_row >= ROWS or wr_col >= COLS SHALL be consumed with no buf_wen pulse.
REQ-019 An accepted command SHALL enter FILL and write blank 0x20, with buf_graphic 0, one location per cycle over a logical index range [start, end).
REQ-020 Ranges: op 0 SHALL be [0, ROWS*COLS); op 1 SHALL be [row*COLS+col, row*COLS+COLS); op 2 SHALL be [row*COLS+col, ROWS*COLS).
REQ-021 For op 3, first_row SHALL increment at acceptance, wrapping ROWS-1 to 0, and the fill range SHALL be logical row ROWS-1 using the new first_row.
REQ-022 During a fill, each logical index SHALL map to physical index + first_row*COLS, minus ROWS*COLS when the result is >= ROWS*COLS.
REQ-023 An op 1 or op 2 with cmd_row >= ROWS or cmd_col >= COLS SHALL be consumed as a no-op and remain in IDLE.
REQ-024 After the last fill write, FILL SHALL return to IDLE, and wr_ready SHALL be high in the following cycle.
REQ-025 busy SHALL equal (state != IDLE); buf_wen SHALL be high exactly once per written location.

Reset
REQ-026 On rst_n low, outputs SHALL immediately take: state IDLE (or INIT), first_row 0, buf_wen 0, buf_waddr 0, buf_din 0, buf_graphic 0, busy 0 (1 if INIT).
REQ-027 Reset during FILL SHALL abort the fill with no further writes; buffer contents are left as partially written.

Configuration
REQ-028 With CHAR_BUF_CTRL_CLEAR_ON_RESET_EN defined, reset release SHALL start INIT, a full-screen blank fill identical to op 0, with both ready outputs low until it completes.
REQ-029 Without CHAR_BUF_CTRL_CLEAR_ON_RESET_EN, reset release SHALL enter IDLE directly, and buffer contents come from the buffer's own initialisation.

Structure
REQ-030 A shared package char_buf_pkg SHALL hold COLS, ROWS, BUF_SIZE (1920), BLANK_CHAR (0x20) and the cmd_op enumeration.
REQ-031 Row/column-to-physical mapping SHALL be a sub-module char_addr_map, using shift-add (r<<6 + r<<4) for *80 with no multiplier.

Verification
REQ-032 Write row 0, col 0, 'A', first_row 0 -> one cycle later buf_wen 1, waddr 0, din 0x41.
REQ-033 Scroll up from first_row 23 -> first_row 0, then 80 writes of 0x20 at waddr 1840..1919, busy high for 80 cycles.
REQ-034 Erase to end of line at row 2, col 70 -> 10 writes, waddr 230..239, then ready.
REQ-035 Erase to end of screen at row 23, col 0 with first_row 5 -> writes at waddr 320..399 only.
REQ-036 wr_valid and cmd_valid both high in IDLE -> write accepted first, command accepted on the next IDLE cycle.
REQ-037 rst_n low mid clear screen after 100 writes -> buf_wen low immediately, first_row 0; with the macro defined, a new 1920-write INIT starts after release.
